// File: rtl/memoir_ff_mem_ctl_if.sv
// Access bundle for the multi-port flop memory: write ports, read ports,
// read results and sticky status flags.
interface memoir_ff_mem_ctl_if #(
  parameter int NUMWPRT = 4,
  parameter int NUMRPRT = 4,
  parameter int BITADDR = 6,
  parameter int WIDTH   = 24
);
  logic                 ready;
  logic [NUMWPRT-1:0]   write;
  logic [BITADDR-1:0]   wr_adr  [NUMWPRT];
  logic [WIDTH-1:0]     din     [NUMWPRT];
  logic [NUMRPRT-1:0]   read;
  logic [BITADDR-1:0]   rd_adr  [NUMRPRT];
  logic [NUMRPRT-1:0]   rd_vld;
  logic [WIDTH-1:0]     rd_dout [NUMRPRT];
  logic [NUMRPRT-1:0]   rd_err;
  logic                 wr_conflict;
  logic                 wr_err;

  modport master (
    input  ready, rd_vld, rd_dout, rd_err, wr_conflict, wr_err,
    output write, wr_adr, din, read, rd_adr
  );

  modport slave (
    output ready, rd_vld, rd_dout, rd_err, wr_conflict, wr_err,
    input  write, wr_adr, din, read, rd_adr
  );
endinterface

// File: rtl/memoir_ff_mem_ctl.sv
// Multi-port flop memory with post-reset init sweep, highest-port write
// priority, optional write-to-read bypass and optional registered read.
module memoir_ff_mem_ctl #(
  parameter int                NUMWPRT = 4,
  parameter int                NUMRPRT = 4,
  parameter int                BITADDR = 6,
  parameter int                NUMADDR = 64,
  parameter int                WIDTH   = 24,
  parameter int                FLOPOUT = 0,
  parameter int                BYPASS  = 1,
  parameter int                RSTINIT = 1,
  parameter logic [WIDTH-1:0]  INITVAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  memoir_ff_mem_ctl_if.slave    bus
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [BITADDR:0]   ADR_LIM  = (BITADDR+1)'(NUMADDR);
  localparam logic [BITADDR-1:0] CNT_LAST = BITADDR'(NUMADDR-1);

  state_e              state_q, state_d;
  logic [BITADDR-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]    mem_q [NUMADDR];
  logic [WIDTH-1:0]    mem_d [NUMADDR];
  logic                wr_conflict_q, wr_conflict_d;
  logic                wr_err_q, wr_err_d;
  logic                ready;
  logic [NUMRPRT-1:0]  rd_vld_d, rd_err_d;
  logic [WIDTH-1:0]    rd_data_d [NUMRPRT];

  function automatic logic in_range(input logic [BITADDR-1:0] adr);
    return {1'b0, adr} < ADR_LIM;
  endfunction

  assign ready           = (state_q == RUN);
  assign bus.ready       = ready;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.wr_err      = wr_err_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_d         = mem_q;
    wr_conflict_d = wr_conflict_q;
    wr_err_d      = wr_err_q;
    if (state_q == INIT) begin
      state_d = RUN;
      if (RSTINIT != 0) begin
        mem_d[cnt_q] = INITVAL;
        cnt_d        = cnt_q + BITADDR'(1);
        if (cnt_q != CNT_LAST) state_d = INIT;
      end
    end else begin
      // ascending port order so the highest enabled port lands last
      for (int w = 0; w < NUMWPRT; w++) begin
        if (bus.write[w]) begin
          if (in_range(bus.wr_adr[w])) mem_d[bus.wr_adr[w]] = bus.din[w];
          else                         wr_err_d = 1'b1;
        end
      end
      for (int i = 0; i < NUMWPRT; i++) begin
        for (int j = i + 1; j < NUMWPRT; j++) begin
          if (bus.write[i] && bus.write[j] && (bus.wr_adr[i] == bus.wr_adr[j]))
            wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      wr_conflict_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_conflict_q <= wr_conflict_d;
      wr_err_q      <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  // Read stage: array lookup with same-cycle forwarding
  always_comb begin
    for (int r = 0; r < NUMRPRT; r++) begin
      rd_vld_d[r]  = bus.read[r] & ready;
      rd_err_d[r]  = 1'b0;
      rd_data_d[r] = '0;
      if (rd_vld_d[r]) begin
        if (!in_range(bus.rd_adr[r])) begin
          rd_err_d[r] = 1'b1;
        end else begin
          rd_data_d[r] = mem_q[bus.rd_adr[r]];
          if (BYPASS != 0) begin
            for (int w = 0; w < NUMWPRT; w++) begin
              if (bus.write[w] && (bus.wr_adr[w] == bus.rd_adr[r]))
                rd_data_d[r] = bus.din[w];
            end
          end
        end
      end
    end
  end

  generate
    if (FLOPOUT != 0) begin : g_flop
      logic [NUMRPRT-1:0] rd_vld_q, rd_err_q;
      logic [WIDTH-1:0]   rd_dout_q [NUMRPRT];
      logic [WIDTH-1:0]   rd_dout_d [NUMRPRT];

      always_comb begin
        for (int r = 0; r < NUMRPRT; r++)
          rd_dout_d[r] = rd_vld_d[r] ? rd_data_d[r] : rd_dout_q[r];
      end

      // Output stage: one-cycle registered read, data held when idle
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_vld_q <= '0;
          rd_err_q <= '0;
          for (int r = 0; r < NUMRPRT; r++) rd_dout_q[r] <= '0;
        end else begin
          rd_vld_q  <= rd_vld_d;
          rd_err_q  <= rd_err_d;
          rd_dout_q <= rd_dout_d;
        end
      end

      assign bus.rd_vld  = rd_vld_q;
      assign bus.rd_err  = rd_err_q;
      assign bus.rd_dout = rd_dout_q;
    end else begin : g_comb
      assign bus.rd_vld  = rd_vld_d;
      assign bus.rd_err  = rd_err_d;
      assign bus.rd_dout = rd_data_d;
    end
  endgenerate

endmodule

// File: tb/tb_memoir_ff_mem_ctl.sv
// Scoreboard bench: four configurations of the memory share one stimulus
// stream; a reference model predicts read results, ready and sticky flags.
module tb_memoir_ff_mem_ctl;

  localparam logic [23:0] INITV = 24'hABCDEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  write_s;
  logic [5:0]  wr_adr_s [4];
  logic [23:0] din_s    [4];
  logic [3:0]  read_s;
  logic [5:0]  rd_adr_s [4];

  logic [3:0]  ready_o, cf_o, we_o;
  logic [3:0]  vld_o  [4];
  logic [3:0]  err_o  [4];
  logic [23:0] dout_o [4][4];

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int NA_G = (g == 3) ? 48 : 64;
      localparam int FO_G = (g == 2) ? 1 : 0;
      localparam int BP_G = (g == 1) ? 0 : 1;

      memoir_ff_mem_ctl_if #(.NUMWPRT(4), .NUMRPRT(4), .BITADDR(6), .WIDTH(24)) bus ();
      memoir_ff_mem_ctl #(.NUMWPRT(4), .NUMRPRT(4), .BITADDR(6), .NUMADDR(NA_G), .WIDTH(24),
        .FLOPOUT(FO_G), .BYPASS(BP_G), .RSTINIT(1), .INITVAL(INITV)) dut (
        .clk(clk), .rst(rst), .bus(bus));

      assign bus.write    = write_s;
      assign bus.wr_adr   = wr_adr_s;
      assign bus.din      = din_s;
      assign bus.read     = read_s;
      assign bus.rd_adr   = rd_adr_s;
      assign ready_o[g]   = bus.ready;
      assign cf_o[g]      = bus.wr_conflict;
      assign we_o[g]      = bus.wr_err;
      assign vld_o[g]     = bus.rd_vld;
      assign err_o[g]     = bus.rd_err;
      assign dout_o[g][0] = bus.rd_dout[0];
      assign dout_o[g][1] = bus.rd_dout[1];
      assign dout_o[g][2] = bus.rd_dout[2];
      assign dout_o[g][3] = bus.rd_dout[3];
    end
  endgenerate

  function automatic int na(input int d); return (d == 3) ? 48 : 64; endfunction
  function automatic int fo(input int d); return (d == 2) ? 1 : 0;   endfunction
  function automatic int bp(input int d); return (d == 1) ? 0 : 1;   endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          port;
    logic [23:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [4][$];
  int          sweep [4];
  logic        cf_m  [4];
  logic        er_m  [4];
  logic [23:0] mem_m [4][64];
  int          cyc = 0;
  bit          started = 1'b0;

  // Reference model advances on every rising edge
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        started  = 1'b1;
        sweep[d] = 0;
        cf_m[d]  = 1'b0;
        er_m[d]  = 1'b0;
        for (int a = 0; a < 64; a++) mem_m[d][a] = INITV;
      end else if (sweep[d] == na(d)) begin
        for (int w = 0; w < 4; w++) begin
          if (write_s[w]) begin
            if (int'(wr_adr_s[w]) < na(d)) mem_m[d][wr_adr_s[w]] = din_s[w];
            else er_m[d] = 1'b1;
          end
          for (int v = w + 1; v < 4; v++)
            if (write_s[w] && write_s[v] && wr_adr_s[w] == wr_adr_s[v]) cf_m[d] = 1'b1;
        end
      end else begin
        sweep[d]++;
      end
    end
  end

  task automatic push_reads();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 4; r++) begin
        if (read_s[r] && sweep[d] == na(d)) begin
          e.due  = cyc + fo(d);
          e.port = r;
          e.err  = (int'(rd_adr_s[r]) >= na(d));
          e.data = 24'h0;
          if (!e.err) begin
            e.data = mem_m[d][rd_adr_s[r]];
            if (bp(d) != 0)
              for (int w = 0; w < 4; w++)
                if (write_s[w] && wr_adr_s[w] == rd_adr_s[r]) e.data = din_s[w];
          end
          sb[d].push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("d%0d.ready", d), 32'(ready_o[d]), 32'(sweep[d] == na(d)));
        chk($sformatf("d%0d.wr_conflict", d), 32'(cf_o[d]), 32'(cf_m[d]));
        chk($sformatf("d%0d.wr_err", d), 32'(we_o[d]), 32'(er_m[d]));
        for (int r = 0; r < 4; r++) begin
          exp_t e;
          bit   ev;
          ev = (sb[d].size() > 0) && (sb[d][0].due == cyc) && (sb[d][0].port == r);
          chk($sformatf("d%0d.rd_vld%0d c%0d", d, r, cyc), 32'(vld_o[d][r]), 32'(ev));
          if (ev) begin
            e = sb[d].pop_front();
            chk($sformatf("d%0d.rd_dout%0d c%0d", d, r, cyc), 32'(dout_o[d][r]), 32'(e.data));
            chk($sformatf("d%0d.rd_err%0d c%0d", d, r, cyc), 32'(err_o[d][r]), 32'(e.err));
          end else begin
            chk($sformatf("d%0d.rd_err_idle%0d", d, r), 32'(err_o[d][r]), 32'd0);
            if (fo(d) == 0)
              chk($sformatf("d%0d.rd_dout_idle%0d", d, r), 32'(dout_o[d][r]), 32'd0);
          end
        end
      end
    end
  end

  task automatic next_cyc();
    push_reads();
    @(posedge clk);
    #1;
    write_s = '0;
    read_s  = '0;
  endtask

  task automatic wr(input int p, input logic [5:0] a, input logic [23:0] v);
    write_s[p]  = 1'b1;
    wr_adr_s[p] = a;
    din_s[p]    = v;
  endtask

  task automatic rd(input int p, input logic [5:0] a);
    read_s[p]   = 1'b1;
    rd_adr_s[p] = a;
  endtask

  initial begin
    int left;
    rst     = 1'b1;
    write_s = '0;
    read_s  = '0;
    for (int i = 0; i < 4; i++) begin
      wr_adr_s[i] = '0; din_s[i] = '0; rd_adr_s[i] = '0;
    end
    next_cyc();
    rst = 1'b0;
    repeat (20) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    rd(0, 6'd3);
    next_cyc();
    repeat (70) next_cyc();

    rd(0, 6'd0); rd(1, 6'd31); rd(2, 6'd63);
    next_cyc();

    wr(0, 6'd5, 24'h000011); wr(3, 6'd5, 24'h000033);
    next_cyc();
    for (int r = 0; r < 4; r++) rd(r, 6'd5);
    next_cyc();

    wr(1, 6'd9, 24'h123456); rd(0, 6'd9);
    next_cyc();
    wr(1, 6'd10, 24'hAAAAAA); wr(2, 6'd10, 24'hBBBBBB); rd(3, 6'd10);
    next_cyc();

    wr(0, 6'd7, 24'h00BEEF);
    next_cyc();
    rd(2, 6'd7);
    next_cyc();
    next_cyc();

    wr(0, 6'd50, 24'h777777);
    next_cyc();
    rd(1, 6'd50);
    next_cyc();

    repeat (300) begin
      for (int w = 0; w < 4; w++)
        if ($urandom_range(0, 2) == 0) wr(w, 6'($urandom_range(0, 63)), 24'($urandom));
      for (int r = 0; r < 4; r++)
        if ($urandom_range(0, 1) == 0) rd(r, 6'($urandom_range(0, 63)));
      next_cyc();
    end

    repeat (3) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    repeat (3) next_cyc();

    left = 0;
    for (int d = 0; d < 4; d++) left += sb[d].size();
    chk("drain", 32'(left), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
